execute_stage: RTL
==================

Name: execute_stage

Overview:
- 64-bit RV64 execute stage, directly upstream of the memory stage. Consumes decoded operands and control from decode; produces ALUResult, WriteData, Rd, Zero, BranchTaken and pass-through control for memory access.
- Single-cycle ALU/MUL/branch ops. Iterative 64-cycle restoring divider for DIV/DIVU/REM/REMU, with a busy handshake back to decode.

Parameters:
XLEN, 64, datapath width (shift amount uses B[5:0]; divider runs XLEN iterations)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
in_valid  in  1  decode presents a valid op
busy  out  1  divider running; inputs ignored
PC  in  64  instruction address
ReadData1  in  64  rs1 value (operand A)
ReadData2  in  64  rs2 value
Imm  in  64  sign-extended immediate
ALUSrc  in  1  1: operand B = Imm, 0: B = ReadData2
ALUOp  in  5  operation code (see Behaviour)
Branch  in  1  op is a conditional branch
Rd  in  5  destination register
MemRead, MemWrite, MemtoReg, RegWrite  in  1 each  control from decode
out_valid  out  1  one-cycle pulse: outputs carry a new result
ALUResult  out  64  result / effective address
WriteData  out  64  registered ReadData2 (store data)
RdOut  out  5  registered Rd
Zero  out  1  ALUResult == 0
BranchTaken  out  1  Branch && condition true
BranchTarget  out  64  PC + Imm
MemReadOut, MemWriteOut, MemtoRegOut, RegWriteOut  out  1 each  registered control

Behaviour:
- Reset (async, active-high): all outputs 0, state IDLE, counter 0, divider registers 0. Memory contents downstream are unaffected.
- ALUOp codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR
  - 5 SLL, 6 SRL, 7 SRA (shift by B[5:0])
  - 8 SLT, 9 SLTU (result 0/1)
  - 10 MUL (low 64 bits)
  - 11 DIV, 12 DIVU, 13 REM, 14 REMU
  - 16 BEQ, 17 BNE, 18 BLT, 19 BGE, 20 BLTU, 21 BGEU: ALUResult = A−B; condition evaluated on A,B
  - Any other code: ALUResult = 0
- Accept: a rising edge with in_valid=1 and state IDLE. While busy=1, in_valid is ignored and causes no state change.
- Single-cycle ops (codes 0–10, 16–21, divide special cases):
  - Result registered at the accept edge; out_valid=1 for exactly the following cycle.
  - WriteData, RdOut and BranchTarget are registered at the same edge.
- State machine, IDLE → DIV_RUN → IDLE:
  - Accepting a divide op with a nonzero, non-overflow divisor enters DIV_RUN, latching operands (magnitudes for signed ops, plus result-sign flags) and setting count=64. busy=1 from the following cycle.
  - Each DIV_RUN edge: shift the remainder/quotient pair one bit, trial-subtract the divisor, set the quotient bit, decrement count.
  - On the edge where count goes 1→0: apply sign correction, register ALUResult, return to IDLE, busy=0, out_valid=1 for one cycle.
  - Total: result valid after accept edge + 64 edges.
  - Control, Rd and WriteData latched at accept are presented with the result.
- Divide special cases, single-cycle, no DIV_RUN:
  - Divisor 0: DIV/DIVU → all ones; REM/REMU → dividend.
  - DIV/REM with dividend 0x8000000000000000 and divisor −1: DIV → dividend; REM → 0.
- Signed rules:
  - Quotient negative iff operand signs differ.
  - Remainder takes the dividend's sign.
- Control outputs:
  - MemReadOut, MemWriteOut and RegWriteOut are high only in out_valid cycles; forced 0 otherwise, so no duplicate writes downstream.
  - MemtoRegOut is registered on completion and held.
- Data outputs: ALUResult, WriteData, RdOut, Zero, BranchTarget hold their values between completions.
- BranchTaken:
  - Equals Branch && cond, registered with the result.
  - Pulses with out_valid and reads 0 otherwise.
- Reset during DIV_RUN: abort immediately, busy=0, out_valid=0, no result emitted. Next accept after reset release works normally.
- Widths: all arithmetic modulo 2^64; SLT/BLT/BGE signed, SLTU/BLTU/BGEU unsigned.

Test Plan:
- ADD: A=5, Imm=7, ALUSrc=1, RegWrite=1, Rd=3 → next cycle ALUResult=12, RdOut=3, RegWriteOut=1, out_valid=1; one cycle later RegWriteOut=0, ALUResult still 12.
- BEQ: A=B=0x55, Branch=1, PC=0x100, Imm=0x20 → BranchTaken=1, BranchTarget=0x120, Zero=1. Repeat with B=0x56 → BranchTaken=0.
- DIVU: A=100, B=7 →
  - busy=1 for 64 cycles;
  - out_valid exactly 64 edges after accept with ALUResult=14;
  - REMU with the same operands → 2;
  - DIV A=−100, B=7 → 0xFFFFFFFFFFFFFFF2.
- Special cases, each with out_valid the next cycle and busy never set:
  - DIV by 0 → 0xFFFFFFFFFFFFFFFF;
  - REM by 0 → dividend;
  - DIV 0x8000000000000000 / −1 → 0x8000000000000000.
- in_valid=1 with ADD 1+1 while busy → ignored: no extra out_valid, and the divide result is unchanged.
- Reset at cycle 30 of DIVU → busy=0 and all outputs 0 immediately. A following ADD 2+2 → ALUResult=4 next cycle.

Source files
------------

// File: rtl/execute_stage.sv
// execute_stage: RV64 execute stage with single-cycle ALU/branch ops and an iterative restoring divider
// Ports: clk, reset (async, active-high); in_valid/busy handshake with decode;
//        PC, ReadData1, ReadData2, Imm, ALUSrc, ALUOp, Branch, Rd, MemRead/MemWrite/MemtoReg/RegWrite in;
//        out_valid, ALUResult, WriteData, RdOut, Zero, BranchTaken, BranchTarget and registered control out.
module execute_stage #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            busy,
    input  logic [XLEN-1:0] PC,
    input  logic [XLEN-1:0] ReadData1,
    input  logic [XLEN-1:0] ReadData2,
    input  logic [XLEN-1:0] Imm,
    input  logic            ALUSrc,
    input  logic [4:0]      ALUOp,
    input  logic            Branch,
    input  logic [4:0]      Rd,
    input  logic            MemRead,
    input  logic            MemWrite,
    input  logic            MemtoReg,
    input  logic            RegWrite,
    output logic            out_valid,
    output logic [XLEN-1:0] ALUResult,
    output logic [XLEN-1:0] WriteData,
    output logic [4:0]      RdOut,
    output logic            Zero,
    output logic            BranchTaken,
    output logic [XLEN-1:0] BranchTarget,
    output logic            MemReadOut,
    output logic            MemWriteOut,
    output logic            MemtoRegOut,
    output logic            RegWriteOut
);
    localparam int SW = $clog2(XLEN);
    localparam int CW = SW + 1;
    typedef enum logic {IDLE, DIV_RUN} state_t;
    state_t state, state_nxt;
    logic [XLEN-1:0] a, b, res, a_mag, b_mag;
    logic cond, is_div, sgn, is_rem_op, div_zero, div_ovf, accept, start_div;
    logic [XLEN-1:0] rem_q, quo_q, dvs_q, r_next, q_next, div_res;
    logic [XLEN:0] r_sh, diff;
    logic ge;
    logic [CW-1:0] cnt;
    logic neg_q, neg_r, rem_sel;
    logic [XLEN-1:0] p_wd, p_tgt;
    logic [4:0] p_rd;
    logic p_mr, p_mw, p_m2r, p_rw;
    logic mr_q, mw_q, rw_q, bt_q;
    assign a = ReadData1;
    assign b = ALUSrc ? Imm : ReadData2;
    assign is_div = ALUOp >= 5'd11 && ALUOp <= 5'd14;
    assign sgn = ALUOp == 5'd11 || ALUOp == 5'd13;
    assign is_rem_op = ALUOp == 5'd13 || ALUOp == 5'd14;
    assign div_zero = b == '0;
    assign div_ovf = sgn && a == {1'b1, {(XLEN-1){1'b0}}} && b == '1;
    assign accept = in_valid && state == IDLE;
    assign start_div = accept && is_div && !div_zero && !div_ovf;
    assign a_mag = (sgn && a[XLEN-1]) ? -a : a;
    assign b_mag = (sgn && b[XLEN-1]) ? -b : b;
    // Divide ops only reach res on their special cases; normal divides go through DIV_RUN.
    always_comb begin
        res = '0;
        cond = 1'b0;
        case (ALUOp)
            5'd0:  res = a + b;
            5'd1:  res = a - b;
            5'd2:  res = a & b;
            5'd3:  res = a | b;
            5'd4:  res = a ^ b;
            5'd5:  res = a << b[SW-1:0];
            5'd6:  res = a >> b[SW-1:0];
            5'd7:  res = $signed(a) >>> b[SW-1:0];
            5'd8:  res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            5'd9:  res = {{(XLEN-1){1'b0}}, a < b};
            5'd10: res = a * b;
            5'd11, 5'd12: res = div_zero ? '1 : a;
            5'd13, 5'd14: res = div_zero ? a : '0;
            5'd16: begin res = a - b; cond = a == b; end
            5'd17: begin res = a - b; cond = a != b; end
            5'd18: begin res = a - b; cond = $signed(a) < $signed(b); end
            5'd19: begin res = a - b; cond = $signed(a) >= $signed(b); end
            5'd20: begin res = a - b; cond = a < b; end
            5'd21: begin res = a - b; cond = a >= b; end
            default: res = '0;
        endcase
    end
    // One restoring step; the extra top bit of diff is the borrow of the trial subtract.
    always_comb begin
        r_sh = {rem_q, quo_q[XLEN-1]};
        diff = r_sh - {1'b0, dvs_q};
        ge = !diff[XLEN];
        r_next = ge ? diff[XLEN-1:0] : r_sh[XLEN-1:0];
        q_next = {quo_q[XLEN-2:0], ge};
        div_res = rem_sel ? (neg_r ? -r_next : r_next) : (neg_q ? -q_next : q_next);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= state_nxt;
    end
    always_comb begin
        state_nxt = (state == IDLE) ? (start_div ? DIV_RUN : IDLE) : (cnt == CW'(1) ? IDLE : DIV_RUN);
    end
    always_comb begin
        busy = state == DIV_RUN;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            ALUResult <= '0;
            Zero <= 1'b0;
            WriteData <= '0;
            RdOut <= '0;
            BranchTarget <= '0;
            MemtoRegOut <= 1'b0;
            mr_q <= 1'b0;
            mw_q <= 1'b0;
            rw_q <= 1'b0;
            bt_q <= 1'b0;
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            rem_sel <= 1'b0;
            p_wd <= '0;
            p_tgt <= '0;
            p_rd <= '0;
            p_mr <= 1'b0;
            p_mw <= 1'b0;
            p_m2r <= 1'b0;
            p_rw <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (accept && !start_div) begin
                out_valid <= 1'b1;
                ALUResult <= res;
                Zero <= res == '0;
                bt_q <= Branch && cond;
                WriteData <= ReadData2;
                RdOut <= Rd;
                BranchTarget <= PC + Imm;
                mr_q <= MemRead;
                mw_q <= MemWrite;
                MemtoRegOut <= MemtoReg;
                rw_q <= RegWrite;
            end else if (start_div) begin
                rem_q <= '0;
                quo_q <= a_mag;
                dvs_q <= b_mag;
                cnt <= CW'(XLEN);
                neg_q <= sgn && (a[XLEN-1] ^ b[XLEN-1]);
                neg_r <= sgn && a[XLEN-1];
                rem_sel <= is_rem_op;
                p_wd <= ReadData2;
                p_tgt <= PC + Imm;
                p_rd <= Rd;
                p_mr <= MemRead;
                p_mw <= MemWrite;
                p_m2r <= MemtoReg;
                p_rw <= RegWrite;
            end else if (state == DIV_RUN) begin
                rem_q <= r_next;
                quo_q <= q_next;
                cnt <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    out_valid <= 1'b1;
                    ALUResult <= div_res;
                    Zero <= div_res == '0;
                    bt_q <= 1'b0;
                    WriteData <= p_wd;
                    RdOut <= p_rd;
                    BranchTarget <= p_tgt;
                    mr_q <= p_mr;
                    mw_q <= p_mw;
                    MemtoRegOut <= p_m2r;
                    rw_q <= p_rw;
                end
            end
        end
    end
    // Write-type controls and BranchTaken only assert in the result cycle.
    assign MemReadOut = out_valid && mr_q;
    assign MemWriteOut = out_valid && mw_q;
    assign RegWriteOut = out_valid && rw_q;
    assign BranchTaken = out_valid && bt_q;
endmodule
